pong_game_controller: RTL
=========================

PONG_GAME_CONTROLLER -- requirements
Module: pong_game_controller

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- H_MIN, 16: left playfield limit.
- H_MAX, 1008: right playfield limit.
- V_MIN, 16: top playfield limit.
- V_MAX, 752: bottom playfield limit.
- RAKET_X, 976: left edge of the racket column.
- RAKET_H, 96: racket height.
- RAKET_STEP, 4: racket pixels moved per tick.
- BALL_STEP, 2: ball pixels moved per tick and axis.
- LIVES, 3: lives at game start.
- MISS_TICKS, 60: ticks spent in MISS.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- pixelClock, in, 1: clock.
- reset, in, 1: asynchronous, active-high.
- frameTick, in, 1: one-cycle update strobe, once per frame.
- raket_up, in, 1: level, move racket up.
- raket_down, in, 1: level, move racket down.
- serve, in, 1: level, start or continue play.
- ball_x, out, 10: ball column.
- ball_y, out, 10: ball row.
- raket_y, out, 10: racket top row.
- score, out, 8: hits counted.
- lives, out, 2: remaining lives.
- state, out, 3: FSM state code.
- hit, out, 1: one-cycle pulse when the ball strikes the racket.
- miss, out, 1: one-cycle pulse when the ball passes the racket.

Function
REQ-003 All state and outputs SHALL change only on the pixelClock edge where frameTick=1; on every other cycle they SHALL hold, and hit and miss SHALL be 0.
REQ-004 Updated values SHALL be visible on the cycle after the tick edge: one register stage, no combinational input-to-output path.
REQ-005 The FSM SHALL have these state codes: IDLE=0, PLAY=1, MISS=2, SERVE=3, OVER=4.
REQ-006 FSM transitions:
- IDLE -> PLAY on tick with serve=1.
- PLAY -> MISS on a miss.
- MISS -> SERVE after MISS_TICKS ticks if lives>0; MISS -> OVER after MISS_TICKS ticks if lives=0.
- SERVE -> PLAY on tick with serve=1.
- OVER -> PLAY on tick with serve=1; this entry SHALL reload score=0 and lives=LIVES.
REQ-007 Racket movement on each tick, in every state:
- If raket_up=1, raket_y SHALL decrease by RAKET_STEP, clamped at V_MIN.
- Else if raket_down=1, raket_y SHALL increase by RAKET_STEP, clamped at V_MAX-RAKET_H.
- If both inputs are 1, up SHALL win.
REQ-008 In PLAY, the ball SHALL move BALL_STEP per tick on each axis in directions dx and dy (0=increasing, 1=decreasing).
REQ-009 Vertical bounce: if the next ball_y is <=V_MIN, ball_y SHALL be set to V_MIN and dy cleared; if the next ball_y is >=V_MAX, ball_y SHALL be set to V_MAX and dy set.
REQ-010 Left-wall bounce: with dx=1, if the next ball_x is <=H_MIN, ball_x SHALL be set to H_MIN and dx cleared.
REQ-011 Racket hit: with dx=0, if the next ball_x is >=RAKET_X and the current ball_y is within [raket_y, raket_y+RAKET_H] inclusive, the block SHALL:
- set ball_x to RAKET_X-1 and set dx;
- pulse hit;
- increment score, saturating at 255.
REQ-012 Miss: with dx=0, if the next ball_x is >=RAKET_X and ball_y is outside the racket span, the block SHALL:
- pulse miss;
- decrement lives, saturating at 0;
- enter MISS.
REQ-013 A vertical bounce and a racket hit in the same tick SHALL both be applied.
REQ-014 Entering SERVE or PLAY from IDLE/SERVE/OVER SHALL place the ball at (512,384) with dx=0; dy SHALL toggle on each serve.
REQ-015 In IDLE, MISS, SERVE and OVER the ball position SHALL hold.
REQ-016 All position arithmetic SHALL use 11-bit intermediates so that no value wraps around.

Reset
REQ-017 On reset=1 the block SHALL asynchronously set:
- state=IDLE;
- ball_x=512, ball_y=384;
- raket_y=(V_MIN+V_MAX-RAKET_H)/2=336;
- score=0, lives=LIVES;
- dx=0, dy=0;
- hit=0, miss=0;
- the miss counter to 0.
REQ-018 Reset asserted mid-play SHALL abandon the current rally, and a tick arriving while reset=1 SHALL be ignored.

Configuration
REQ-019 With macro PONG_SPEEDUP_EN defined, the effective ball step SHALL be BALL_STEP+score/8, capped at 4*BALL_STEP.
REQ-020 With PONG_SPEEDUP_EN undefined, the ball step SHALL be the constant BALL_STEP.

Verification
REQ-021 Reset release, raket_down held for 200 ticks -> raket_y reaches 656 and holds at 656.
REQ-022 IDLE, serve=1 with a tick -> state=1; after 10 ticks ball_x=532 and ball_y=404.
REQ-023 ball_x=974, dx=0, raket_y=336, ball_y=400 -> hit pulse one cycle, ball_x=975, dx=1, score=1.
REQ-024 Same as REQ-023 with ball_y=500 -> miss pulse, lives=2, state=2; after 60 ticks state=3.
REQ-025 Three misses -> state=4, lives=0; serve -> state=1, lives=3, score=0.
REQ-026 Reset asserted mid-PLAY -> all outputs at REQ-017 values the same cycle; with PONG_SPEEDUP_EN and score=16, the ball moves 4 pixels per tick.

Source files
------------

// File: rtl/pong_game_controller.sv
// pong_game_controller: frame-tick driven single-player pong (ball, racket, score, lives FSM).
// Optional macro PONG_SPEEDUP_EN: ball step grows with score (BALL_STEP + score/8, capped at 4*BALL_STEP).
module pong_game_controller #(
   parameter int H_MIN      = 16,
   parameter int H_MAX      = 1008,
   parameter int V_MIN      = 16,
   parameter int V_MAX      = 752,
   parameter int RAKET_X    = 976,
   parameter int RAKET_H    = 96,
   parameter int RAKET_STEP = 4,
   parameter int BALL_STEP  = 2,
   parameter int LIVES      = 3,
   parameter int MISS_TICKS = 60
) (
   input  logic       pixelClock,
   input  logic       reset,
   input  logic       frameTick,
   input  logic       raket_up,
   input  logic       raket_down,
   input  logic       serve,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [9:0] raket_y,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic [2:0] state,
   output logic       hit,
   output logic       miss
);
   typedef enum logic [2:0] {S_IDLE = 3'd0, S_PLAY = 3'd1, S_MISS = 3'd2, S_SERVE = 3'd3, S_OVER = 3'd4} state_t;
   localparam logic [9:0] CX = 10'd512;
   localparam logic [9:0] CY = 10'd384;
   localparam logic [9:0] RY0 = 10'((V_MIN + V_MAX - RAKET_H) / 2);
   state_t r_state, w_state;
   logic [9:0] r_bx, r_by, r_ry, w_bx, w_by, w_ry;
   logic [7:0] r_score, w_score, r_cnt, w_cnt;
   logic [1:0] r_lives, w_lives;
   logic r_dx, r_dy, w_dx, w_dy, r_hit, r_miss, w_hit, w_miss;
   logic [10:0] w_step, w_nx, w_ny;
   logic w_wall, w_top, w_bot, w_edge, w_span;
`ifdef PONG_SPEEDUP_EN
   logic [10:0] w_sum;
   assign w_sum  = 11'(BALL_STEP) + 11'(r_score[7:3]);
   assign w_step = (w_sum > 11'(4 * BALL_STEP)) ? 11'(4 * BALL_STEP) : w_sum;
`else
   assign w_step = 11'(BALL_STEP);
`endif
   // next-position compares are guarded so the 11-bit math never wraps
   assign w_nx   = r_dx ? {1'b0, r_bx} - w_step : {1'b0, r_bx} + w_step;
   assign w_ny   = r_dy ? {1'b0, r_by} - w_step : {1'b0, r_by} + w_step;
   assign w_wall = r_dx && ({1'b0, r_bx} <= 11'(H_MIN) + w_step);
   assign w_top  = r_dy && ({1'b0, r_by} <= 11'(V_MIN) + w_step);
   assign w_bot  = !r_dy && (w_ny >= 11'(V_MAX));
   assign w_edge = !r_dx && (w_nx >= 11'(RAKET_X));
   assign w_span = ({1'b0, r_by} >= {1'b0, r_ry}) && ({1'b0, r_by} <= {1'b0, r_ry} + 11'(RAKET_H));
   assign w_ry = raket_up ? (({1'b0, r_ry} <= 11'(V_MIN + RAKET_STEP)) ? 10'(V_MIN) : r_ry - 10'(RAKET_STEP)) :
                 raket_down ? (({1'b0, r_ry} + 11'(RAKET_STEP) >= 11'(V_MAX - RAKET_H)) ? 10'(V_MAX - RAKET_H) : r_ry + 10'(RAKET_STEP)) :
                 r_ry;
   always_comb begin
      w_state = r_state;
      w_bx    = r_bx;
      w_by    = r_by;
      w_dx    = r_dx;
      w_dy    = r_dy;
      w_score = r_score;
      w_lives = r_lives;
      w_cnt   = r_cnt;
      w_hit   = 1'b0;
      w_miss  = 1'b0;
      case (r_state)
         S_PLAY: begin
            w_by    = w_top ? 10'(V_MIN) : w_bot ? 10'(V_MAX) : w_ny[9:0];
            w_dy    = w_top ? 1'b0 : w_bot ? 1'b1 : r_dy;
            w_hit   = w_edge && w_span;
            w_miss  = w_edge && !w_span;
            w_bx    = w_wall ? 10'(H_MIN) : w_hit ? 10'(RAKET_X - 1) : w_nx[9:0];
            w_dx    = w_wall ? 1'b0 : w_hit ? 1'b1 : r_dx;
            w_score = (w_hit && r_score != 8'hFF) ? r_score + 8'd1 : r_score;
            w_lives = (w_miss && r_lives != 2'd0) ? r_lives - 2'd1 : r_lives;
            w_state = w_miss ? S_MISS : S_PLAY;
            w_cnt   = 8'd0;
         end
         S_MISS: begin
            w_cnt = r_cnt + 8'd1;
            if (r_cnt == 8'(MISS_TICKS - 1)) begin
               w_cnt   = 8'd0;
               w_state = (r_lives != 2'd0) ? S_SERVE : S_OVER;
               if (r_lives != 2'd0) begin
                  w_bx = CX;
                  w_by = CY;
                  w_dx = 1'b0;
                  w_dy = ~r_dy;
               end
            end
         end
         S_IDLE, S_SERVE, S_OVER: begin
            if (serve) begin
               w_state = S_PLAY;
               w_bx    = CX;
               w_by    = CY;
               w_dx    = 1'b0;
               w_score = (r_state == S_OVER) ? 8'd0 : r_score;
               w_lives = (r_state == S_OVER) ? 2'(LIVES) : r_lives;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end
   always_ff @(posedge pixelClock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_bx    <= CX;
         r_by    <= CY;
         r_ry    <= RY0;
         r_score <= 8'd0;
         r_lives <= 2'(LIVES);
         r_dx    <= 1'b0;
         r_dy    <= 1'b0;
         r_cnt   <= 8'd0;
         r_hit   <= 1'b0;
         r_miss  <= 1'b0;
      end else begin
         r_hit  <= frameTick & w_hit;
         r_miss <= frameTick & w_miss;
         if (frameTick) begin
            r_state <= w_state;
            r_bx    <= w_bx;
            r_by    <= w_by;
            r_ry    <= w_ry;
            r_score <= w_score;
            r_lives <= w_lives;
            r_dx    <= w_dx;
            r_dy    <= w_dy;
            r_cnt   <= w_cnt;
         end
      end
   end
   assign ball_x  = r_bx;
   assign ball_y  = r_by;
   assign raket_y = r_ry;
   assign score   = r_score;
   assign lives   = r_lives;
   assign state   = r_state;
   assign hit     = r_hit;
   assign miss    = r_miss;
endmodule
